// File: rtl/fabric_ingress_scheduler.sv
// Round-robin arbiter that feeds one frame at a time from the ingress FIFOs to the shared MAC table.
// It then holds the resulting forwarding decision until the datapath completes the frame or the watchdog fires.
module fabric_ingress_scheduler #(
    parameter int NUM_PORTS      = 28,
    parameter int PORT_BITS      = 5,
    parameter int LOOKUP_LATENCY = 2,
    parameter int TIMEOUT        = 4095
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    req,
    input  logic [NUM_PORTS*48-1:0] hdr_src_mac,
    input  logic [NUM_PORTS*48-1:0] hdr_dst_mac,
    input  logic [NUM_PORTS*12-1:0] hdr_vlan,
    output logic                    lookup_en,
    output logic [11:0]             lookup_src_vlan,
    output logic [47:0]             lookup_src_mac,
    output logic [PORT_BITS-1:0]    lookup_src_port,
    output logic [47:0]             lookup_dst_mac,
    input  logic                    lookup_hit,
    input  logic [PORT_BITS-1:0]    lookup_dst_port,
    output logic [NUM_PORTS-1:0]    grant,
    output logic                    grant_valid,
    output logic [PORT_BITS-1:0]    grant_src_port,
    output logic [PORT_BITS-1:0]    grant_dst_port,
    output logic                    grant_flood,
    output logic                    grant_drop,
    input  logic                    grant_done,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WAIT,
        FORWARD
    } state_t;

    state_t               state;
    logic [PORT_BITS-1:0] rr_ptr;
    logic [15:0]          wait_cnt;
    logic [15:0]          wd_cnt;

    logic                 sel_found;
    logic [PORT_BITS-1:0] sel_idx;
    logic [PORT_BITS:0]   cand;
    logic [PORT_BITS-1:0] next_ptr;

    // Scan from rr_ptr upward with wrap; the first requester found wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, rr_ptr} + (PORT_BITS+1)'(i);
            if (cand >= (PORT_BITS+1)'(NUM_PORTS))
                cand = cand - (PORT_BITS+1)'(NUM_PORTS);
            if (!sel_found && req[cand[PORT_BITS-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PORT_BITS-1:0];
            end
        end
    end

    assign next_ptr = (lookup_src_port == PORT_BITS'(NUM_PORTS - 1)) ? '0
                                                                      : lookup_src_port + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            wait_cnt        <= '0;
            wd_cnt          <= '0;
            lookup_en       <= 1'b0;
            lookup_src_vlan <= '0;
            lookup_src_mac  <= '0;
            lookup_src_port <= '0;
            lookup_dst_mac  <= '0;
            grant           <= '0;
            grant_valid     <= 1'b0;
            grant_src_port  <= '0;
            grant_dst_port  <= '0;
            grant_flood     <= 1'b0;
            grant_drop      <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            lookup_en   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        lookup_src_port <= sel_idx;
                        lookup_src_mac  <= hdr_src_mac[int'(sel_idx)*48 +: 48];
                        lookup_dst_mac  <= hdr_dst_mac[int'(sel_idx)*48 +: 48];
                        lookup_src_vlan <= hdr_vlan[int'(sel_idx)*12 +: 12];
                        lookup_en       <= 1'b1;
                        state           <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    wait_cnt <= 16'd1;
                    state    <= WAIT;
                end
                WAIT: begin
                    // The table answer is only trusted on the cycle it is defined to be valid.
                    if (wait_cnt == 16'(LOOKUP_LATENCY)) begin
                        grant          <= NUM_PORTS'(1) << lookup_src_port;
                        grant_valid    <= 1'b1;
                        grant_src_port <= lookup_src_port;
                        grant_dst_port <= lookup_dst_port;
                        grant_flood    <= !lookup_hit;
                        grant_drop     <= lookup_hit && (lookup_dst_port == lookup_src_port);
                        wd_cnt         <= '0;
                        state          <= FORWARD;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                FORWARD: begin
                    // A done that coincides with watchdog expiry takes priority, so no error pulse.
                    if (grant_done || (wd_cnt == 16'(TIMEOUT - 1))) begin
                        grant          <= '0;
                        grant_valid    <= 1'b0;
                        grant_src_port <= '0;
                        grant_dst_port <= '0;
                        grant_flood    <= 1'b0;
                        grant_drop     <= 1'b0;
                        timeout_err    <= !grant_done;
                        rr_ptr         <= next_ptr;
                        state          <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_ingress_scheduler.sv
// Scoreboard bench: stimulus pushes expected lookups and grants, a negedge monitor pops and compares.
// A latency-accurate MAC table model drives wrong data on every cycle except the valid one.
module tb_fabric_ingress_scheduler;

    localparam int NUM_PORTS = 28;
    localparam int PORT_BITS = 5;
    localparam int LAT       = 2;
    localparam int TMO       = 10;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_PORTS-1:0]    req;
    logic [NUM_PORTS*48-1:0] hdr_src_mac;
    logic [NUM_PORTS*48-1:0] hdr_dst_mac;
    logic [NUM_PORTS*12-1:0] hdr_vlan;
    logic                    lookup_en;
    logic [11:0]             lookup_src_vlan;
    logic [47:0]             lookup_src_mac;
    logic [PORT_BITS-1:0]    lookup_src_port;
    logic [47:0]             lookup_dst_mac;
    logic                    lookup_hit = 1'b0;
    logic [PORT_BITS-1:0]    lookup_dst_port = '0;
    logic [NUM_PORTS-1:0]    grant;
    logic                    grant_valid;
    logic [PORT_BITS-1:0]    grant_src_port;
    logic [PORT_BITS-1:0]    grant_dst_port;
    logic                    grant_flood;
    logic                    grant_drop;
    logic                    grant_done = 1'b0;
    logic                    timeout_err;

    fabric_ingress_scheduler #(
        .NUM_PORTS(NUM_PORTS), .PORT_BITS(PORT_BITS),
        .LOOKUP_LATENCY(LAT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .hdr_src_mac(hdr_src_mac), .hdr_dst_mac(hdr_dst_mac), .hdr_vlan(hdr_vlan),
        .lookup_en(lookup_en), .lookup_src_vlan(lookup_src_vlan),
        .lookup_src_mac(lookup_src_mac), .lookup_src_port(lookup_src_port),
        .lookup_dst_mac(lookup_dst_mac), .lookup_hit(lookup_hit),
        .lookup_dst_port(lookup_dst_port), .grant(grant), .grant_valid(grant_valid),
        .grant_src_port(grant_src_port), .grant_dst_port(grant_dst_port),
        .grant_flood(grant_flood), .grant_drop(grant_drop),
        .grant_done(grant_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int src;
        int dst;
        bit flood;
        bit drop;
        bit to;
        int len;
    } exp_t;

    exp_t gr_q[$];
    int   lk_q[$];

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   issued[32];
    int   served[32];
    bit   resp_hit[32];
    logic [PORT_BITS-1:0] resp_dst[32];
    int   done_at[32];

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_PORTS; i++) req[i] = (issued[i] != served[i]);
    end

    function automatic logic [47:0] src_mac_of(input int p);
        return {16'h0200, 8'(p * 7), 8'hBE, 8'h00, 8'(p)};
    endfunction

    function automatic logic [47:0] dst_mac_of(input int p);
        return {16'h00AA, 8'(p * 3), 8'h55, 8'h11, 8'(p + 100)};
    endfunction

    function automatic logic [11:0] vlan_of(input int p);
        return 12'h100 + 12'(p * 5);
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic record_fail(input string name, input int actual);
        checks++;
        $display("[TB] FAIL %s: got %0d, expected none (t=%0t)", name, actual, $time);
    endtask

    task automatic expect_lookup(input int src);
        lk_q.push_back(src);
    endtask

    task automatic expect_frame(input int src, input int dst, input bit flood, input bit drop,
                                input bit to, input int len);
        exp_t e;
        e.src = src; e.dst = dst; e.flood = flood; e.drop = drop; e.to = to; e.len = len;
        lk_q.push_back(src);
        gr_q.push_back(e);
    endtask

    task automatic apply_stimulus(input int port);
        issued[port]++;
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, "_ctrl"}, 128'({lookup_en, grant_valid, grant_flood, grant_drop, timeout_err}), 128'(0));
        check_output({name, "_grant"}, 128'(grant), 128'(0));
        check_output({name, "_lookup_data"},
                     128'({lookup_src_mac, lookup_dst_mac, lookup_src_vlan, lookup_src_port}), 128'(0));
        check_output({name, "_grant_data"}, 128'({grant_src_port, grant_dst_port}), 128'(0));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(gr_q.size() == 0 && lk_q.size() == 0 && !grant_valid && req == '0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) record_fail("wait_idle_expired", n);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // MAC table model: the answer is correct only on the cycle LAT after lookup_en.
    int pend_cyc = -100;
    int pend_port = 0;
    always @(negedge clk) begin
        if (lookup_en) begin
            pend_cyc  = cyc;
            pend_port = int'(lookup_src_port);
        end
        if (cyc == pend_cyc + LAT) begin
            lookup_hit      = resp_hit[pend_port];
            lookup_dst_port = resp_dst[pend_port];
        end else begin
            lookup_hit      = ~resp_hit[pend_port];
            lookup_dst_port = resp_dst[pend_port] ^ 5'd1;
        end
    end

    // Datapath model: done after done_at[port] FORWARD cycles, never when negative.
    int fcount = 0;
    always @(negedge clk) begin
        if (grant_valid && !rst) begin
            grant_done = (done_at[grant_src_port] == fcount);
            fcount++;
        end else begin
            grant_done = 1'b0;
            fcount     = 0;
        end
    end

    exp_t cur;
    exp_t it;
    int   rise_cyc = 0;
    bit   prev_gv = 1'b0;
    bit   prev_le = 1'b0;
    int   te_count = 0;
    int   lp;

    always @(negedge clk) begin
        if (rst) begin
            prev_gv = 1'b0;
            prev_le = 1'b0;
        end else begin
            if (timeout_err) te_count++;
            if (lookup_en) begin
                check_output("lookup_single_cycle", 128'(prev_le), 128'(0));
                if (int'(lookup_src_port) < NUM_PORTS) served[lookup_src_port]++;
                if (lk_q.size() == 0) begin
                    record_fail("lookup_unexpected_port", int'(lookup_src_port));
                end else begin
                    lp = lk_q.pop_front();
                    check_output("lookup_src_port", 128'(lookup_src_port), 128'(lp));
                    check_output("lookup_src_mac", 128'(lookup_src_mac), 128'(src_mac_of(lp)));
                    check_output("lookup_dst_mac", 128'(lookup_dst_mac), 128'(dst_mac_of(lp)));
                    check_output("lookup_src_vlan", 128'(lookup_src_vlan), 128'(vlan_of(lp)));
                end
            end
            prev_le = lookup_en;

            if (grant_valid && !prev_gv) begin
                if (gr_q.size() == 0) begin
                    record_fail("grant_unexpected_port", int'(grant_src_port));
                    cur.to = 1'b0; cur.len = -1;
                end else begin
                    it = gr_q.pop_front();
                    cur = it;
                    check_output("grant_onehot", 128'(grant), 128'(28'(1) << it.src));
                    check_output("grant_src_port", 128'(grant_src_port), 128'(it.src));
                    check_output("grant_flood", 128'(grant_flood), 128'(it.flood));
                    check_output("grant_drop", 128'(grant_drop), 128'(it.drop));
                    check_output("flood_drop_exclusive", 128'(grant_flood & grant_drop), 128'(0));
                    if (!it.flood && !it.drop)
                        check_output("grant_dst_port", 128'(grant_dst_port), 128'(it.dst));
                end
                rise_cyc = cyc;
            end
            if (!grant_valid && prev_gv && cur.len >= 0) begin
                check_output("timeout_err_on_release", 128'(timeout_err), 128'(cur.to));
                check_output("forward_cycles", 128'(cyc - rise_cyc), 128'(cur.len));
            end
            prev_gv = grant_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: simulation did not finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            issued[i] = 0; served[i] = 0; resp_hit[i] = 1'b0; resp_dst[i] = '0; done_at[i] = 0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            hdr_src_mac[48*i +: 48] = src_mac_of(i);
            hdr_dst_mac[48*i +: 48] = dst_mac_of(i);
            hdr_vlan[12*i +: 12]    = vlan_of(i);
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_initial");
        release_reset();

        $display("[TB] single requester, port 5 -> unicast 7");
        resp_hit[5] = 1'b1; resp_dst[5] = 5'd7; done_at[5] = 1;
        expect_frame(5, 7, 0, 0, 0, 2);
        @(negedge clk);
        apply_stimulus(5);
        @(posedge clk); #1;
        check_output("single_lookup_en_t1", 128'(lookup_en), 128'(1));
        @(posedge clk); @(posedge clk); #1;
        check_output("single_grant_valid_t3", 128'(grant_valid), 128'(0));
        @(posedge clk); #1;
        check_output("single_grant_valid_t4", 128'(grant_valid), 128'(1));
        wait_idle(50);

        $display("[TB] pointer after port 5 is 6: ports 5,9 -> 9 then 5");
        resp_hit[9] = 1'b1; resp_dst[9] = 5'd3; done_at[9] = 0;
        done_at[5] = 0;
        expect_frame(9, 3, 0, 0, 0, 1);
        expect_frame(5, 7, 0, 0, 0, 1);
        @(negedge clk);
        apply_stimulus(5); apply_stimulus(9);
        wait_idle(60);

        $display("[TB] decisions: port 8 miss -> flood, port 12 self -> drop");
        resp_hit[8]  = 1'b0; resp_dst[8]  = 5'd2;  done_at[8]  = 0;
        resp_hit[12] = 1'b1; resp_dst[12] = 5'd12; done_at[12] = 2;
        expect_frame(8, 2, 1, 0, 0, 1);
        expect_frame(12, 12, 0, 1, 0, 3);
        @(negedge clk);
        apply_stimulus(12); apply_stimulus(8);
        wait_idle(60);

        $display("[TB] wrap: pointer 27, ports 3,27 -> 27 then 3");
        resp_hit[26] = 1'b1; resp_dst[26] = 5'd1;  done_at[26] = 0;
        resp_hit[27] = 1'b1; resp_dst[27] = 5'd0;  done_at[27] = 0;
        resp_hit[3]  = 1'b1; resp_dst[3]  = 5'd20; done_at[3]  = 0;
        expect_frame(26, 1, 0, 0, 0, 1);
        @(negedge clk);
        apply_stimulus(26);
        wait_idle(40);
        expect_frame(27, 0, 0, 0, 0, 1);
        expect_frame(3, 20, 0, 0, 0, 1);
        @(negedge clk);
        apply_stimulus(3); apply_stimulus(27);
        wait_idle(60);

        $display("[TB] watchdog: port 6 done on cycle 10, port 2 never done, then port 3");
        resp_hit[6] = 1'b1; resp_dst[6] = 5'd1; done_at[6] = 9;
        resp_hit[2] = 1'b1; resp_dst[2] = 5'd9; done_at[2] = -1;
        expect_frame(6, 1, 0, 0, 0, 10);
        expect_frame(2, 9, 0, 0, 1, 10);
        expect_frame(3, 20, 0, 0, 0, 1);
        @(negedge clk);
        apply_stimulus(2); apply_stimulus(3); apply_stimulus(6);
        wait_idle(120);

        $display("[TB] reset during WAIT, then ports 0,15 -> 0 first");
        resp_hit[10] = 1'b1; resp_dst[10] = 5'd4; done_at[10] = 0;
        expect_lookup(10);
        @(negedge clk);
        apply_stimulus(10);
        @(posedge clk);
        pulse_reset();
        check_reset_outputs("reset_in_wait");
        release_reset();
        resp_hit[0]  = 1'b1; resp_dst[0]  = 5'd5; done_at[0]  = 0;
        resp_hit[15] = 1'b0; resp_dst[15] = 5'd0; done_at[15] = 0;
        expect_frame(0, 5, 0, 0, 0, 1);
        expect_frame(15, 0, 1, 0, 0, 1);
        @(negedge clk);
        apply_stimulus(15); apply_stimulus(0);
        wait_idle(60);

        $display("[TB] reset during FORWARD, then ports 0,20 -> 0 first");
        resp_hit[11] = 1'b1; resp_dst[11] = 5'd6; done_at[11] = -1;
        expect_frame(11, 6, 0, 0, 0, 0);
        @(negedge clk);
        apply_stimulus(11);
        begin
            int n;
            n = 0;
            while (!grant_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 20) record_fail("forward_entry_expired", n);
        end
        repeat (2) @(posedge clk);
        pulse_reset();
        check_reset_outputs("reset_in_forward");
        release_reset();
        resp_hit[20] = 1'b1; resp_dst[20] = 5'd21; done_at[20] = 0;
        expect_frame(0, 5, 0, 0, 0, 1);
        expect_frame(20, 21, 0, 0, 0, 1);
        @(negedge clk);
        apply_stimulus(20); apply_stimulus(0);
        wait_idle(60);

        $display("[TB] fairness: all ports requesting, order 0..27 then 0");
        pulse_reset();
        release_reset();
        for (int i = 0; i < NUM_PORTS; i++) begin
            resp_hit[i] = 1'b1;
            resp_dst[i] = (i == NUM_PORTS - 1) ? 5'd0 : 5'(i + 1);
            done_at[i]  = 0;
            expect_frame(i, (i == NUM_PORTS - 1) ? 0 : i + 1, 0, 0, 0, 1);
        end
        expect_frame(0, 1, 0, 0, 0, 1);
        @(negedge clk);
        for (int i = 0; i < NUM_PORTS; i++) apply_stimulus(i);
        apply_stimulus(0);
        wait_idle(400);

        check_output("timeout_pulse_count", 128'(te_count), 128'(1));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
